// File: rtl/l2_access_ctrl.sv
// L2 access sequencer: tag lookup, miss/upgrade bus traffic, tag/MESI/LRU commit, response.
// Owns the hit/miss statistics; one request in flight at a time.

module l2_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt <= '0;
    else if (inc && (cnt != {W{1'b1}})) cnt <= cnt + 1'b1;
  end
endmodule

module l2_access_ctrl #(
  parameter int INDEX_BITS = 14,
  parameter int TAG_BITS   = 12,
  parameter int WAY_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_cmd,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [TAG_BITS-1:0]   req_tag,
  output logic                  arr_rd,
  output logic [INDEX_BITS-1:0] arr_index,
  input  logic                  arr_hit,
  input  logic [WAY_BITS-1:0]   arr_hit_way,
  input  logic [1:0]            arr_hit_mesi,
  input  logic [WAY_BITS-1:0]   arr_victim_way,
  input  logic [TAG_BITS-1:0]   arr_victim_tag,
  input  logic [1:0]            arr_victim_mesi,
  output logic                  arr_wr,
  output logic [WAY_BITS-1:0]   arr_wr_way,
  output logic [TAG_BITS-1:0]   arr_wr_tag,
  output logic [1:0]            arr_wr_mesi,
  output logic                  bus_req,
  output logic [1:0]            bus_cmd,
  output logic [TAG_BITS-1:0]   bus_tag,
  output logic [INDEX_BITS-1:0] bus_index,
  input  logic                  bus_ack,
  input  logic [1:0]            bus_snoop,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [WAY_BITS-1:0]   resp_way,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);
  localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
  localparam logic [1:0] BUS_READ = 2'd0, BUS_RWIM = 2'd1, BUS_WB = 2'd2, BUS_INV = 2'd3;
  localparam logic [1:0] SNP_HIT = 2'd1, SNP_HITM = 2'd2;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, COMPARE, WB, FETCH, INV, UPDATE, RESP
  } state_t;

  typedef struct packed {
    logic                  cmd;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
  } req_t;

  state_t              state;
  req_t                rq;
  logic                hit_q;
  logic [WAY_BITS-1:0] way_q;
  logic [TAG_BITS-1:0] vtag_q;
  logic [1:0]          mesi_q;

  logic [1:0]          cnt_inc;
  logic [1:0][15:0]    cnt_q;

  assign cnt_inc[0] = (state == COMPARE) &&  arr_hit;
  assign cnt_inc[1] = (state == COMPARE) && !arr_hit;

  for (genvar c = 0; c < 2; c++) begin : g_cnt
    l2_sat_cnt #(.W(16)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc[c]),
      .cnt   (cnt_q[c])
    );
  end

  assign hit_cnt  = cnt_q[0];
  assign miss_cnt = cnt_q[1];

  // Everything below is a flop; index/way/tag/state outputs come straight off the request registers.
  assign arr_index   = rq.index;
  assign bus_index   = rq.index;
  assign arr_wr_way  = way_q;
  assign arr_wr_tag  = rq.tag;
  assign arr_wr_mesi = mesi_q;
  assign resp_hit    = hit_q;
  assign resp_way    = way_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rq         <= '0;
      hit_q      <= 1'b0;
      way_q      <= '0;
      vtag_q     <= '0;
      mesi_q     <= MESI_I;
      req_ready  <= 1'b1;
      arr_rd     <= 1'b0;
      arr_wr     <= 1'b0;
      bus_req    <= 1'b0;
      bus_cmd    <= BUS_READ;
      bus_tag    <= '0;
      resp_valid <= 1'b0;
    end else begin
      arr_rd     <= 1'b0;
      arr_wr     <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            rq        <= '{cmd: req_cmd, index: req_index, tag: req_tag};
            req_ready <= 1'b0;
            arr_rd    <= 1'b1;
            state     <= LOOKUP;
          end
        end
        LOOKUP: state <= COMPARE;
        COMPARE: begin
          hit_q  <= arr_hit;
          vtag_q <= arr_victim_tag;
          if (arr_hit) begin
            way_q <= arr_hit_way;
            if (!rq.cmd) begin
              mesi_q <= arr_hit_mesi;
              arr_wr <= 1'b1;
              state  <= UPDATE;
            end else if (arr_hit_mesi == MESI_S) begin
              mesi_q <= MESI_M;
              state  <= INV;
            end else begin
              mesi_q <= MESI_M;
              arr_wr <= 1'b1;
              state  <= UPDATE;
            end
          end else begin
            way_q <= arr_victim_way;
            state <= (arr_victim_mesi == MESI_M) ? WB : FETCH;
          end
        end
        // Bus phases: raise on the first cycle, drop on ack so bus_req idles one cycle between phases.
        WB: begin
          if (!bus_req) begin
            bus_req <= 1'b1;
            bus_cmd <= BUS_WB;
            bus_tag <= vtag_q;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (!bus_req) begin
            bus_req <= 1'b1;
            bus_cmd <= rq.cmd ? BUS_RWIM : BUS_READ;
            bus_tag <= rq.tag;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            if (rq.cmd)                                         mesi_q <= MESI_M;
            else if (bus_snoop == SNP_HIT || bus_snoop == SNP_HITM) mesi_q <= MESI_S;
            else                                                mesi_q <= MESI_E;
            arr_wr  <= 1'b1;
            state   <= UPDATE;
          end
        end
        INV: begin
          if (!bus_req) begin
            bus_req <= 1'b1;
            bus_cmd <= BUS_INV;
            bus_tag <= rq.tag;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            mesi_q  <= MESI_M;
            arr_wr  <= 1'b1;
            state   <= UPDATE;
          end
        end
        UPDATE: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
